// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared encodings for the memory command path. The controller's size
// decoder and the data memory unit both import this package so that the
// store/load codes and the responder FSM encoding cannot drift apart.
//   MEMWRITE_*  : 2-bit store size code (none / byte / half / word)
//   SIZELOAD_*  : 3-bit load code, equal to the load instruction's funct3
//   S_*         : data memory unit FSM state encoding
// Helper functions classify a request's alignment/legality from its size
// code and the two low address bits.
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam logic [1:0] MEMWRITE_NONE = 2'b00;
    localparam logic [1:0] MEMWRITE_SB   = 2'b01;
    localparam logic [1:0] MEMWRITE_SH   = 2'b10;
    localparam logic [1:0] MEMWRITE_SW   = 2'b11;

    localparam logic [2:0] SIZELOAD_LB  = 3'b000;
    localparam logic [2:0] SIZELOAD_LH  = 3'b001;
    localparam logic [2:0] SIZELOAD_LW  = 3'b010;
    localparam logic [2:0] SIZELOAD_LBU = 3'b100;
    localparam logic [2:0] SIZELOAD_LHU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Store is misaligned when a half crosses a half boundary or a word is
    // not word aligned. Byte stores are always aligned.
    function automatic logic store_misaligned(input logic [1:0] memwrite,
                                              input logic [1:0] addr_lo);
        case (memwrite)
            MEMWRITE_SH: return addr_lo[0];
            MEMWRITE_SW: return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Load is illegal for unlisted size codes or for misaligned half/word.
    function automatic logic load_illegal(input logic [2:0] sizeload,
                                          input logic [1:0] addr_lo);
        case (sizeload)
            SIZELOAD_LB, SIZELOAD_LBU: return 1'b0;
            SIZELOAD_LH, SIZELOAD_LHU: return addr_lo[0];
            SIZELOAD_LW:               return (addr_lo != 2'b00);
            default:                   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// ---------------------------------------------------------------------------
// data_memory_unit_if
// Request/response bus between the datapath (master) and the data memory
// unit (slave).
//   req_valid/req_ready   : request handshake
//   req_addr              : byte address (ALU result)
//   req_wdata             : store data, LSB aligned (rs2)
//   req_memwrite          : store size code (MEMWRITE_*)
//   req_load              : load request
//   req_sizeload          : load size/sign code (SIZELOAD_*)
//   resp_valid/resp_ready : response handshake
//   resp_rdata            : extended load data, 0 for stores and errors
//   resp_err              : request rejected without side effect
// ---------------------------------------------------------------------------
interface data_memory_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_memwrite;
    logic              req_load;
    logic [2:0]        req_sizeload;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_memwrite, req_load,
               req_sizeload, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_memwrite, req_load,
               req_sizeload, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align (combinational)
// Store side: turns the store size code and address low bits into a 4-bit
// byte enable and replicates the LSB-aligned store data onto every lane so
// the enabled lanes pick up the right bytes.
// Load side: selects the addressed byte/half from the read word and sign- or
// zero-extends it according to the load code; LW passes the word through.
//   i_memwrite, i_st_lo, i_wdata -> o_be, o_wdata
//   i_sizeload, i_ld_lo, i_rword -> o_rdata (0 for unlisted codes)
// ---------------------------------------------------------------------------
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  i_memwrite,
    input  logic [1:0]  i_st_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_sizeload,
    input  logic [1:0]  i_ld_lo,
    input  logic [31:0] i_rword,
    output logic [31:0] o_rdata
);

    function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
        logic signed [31:0] r;
        r = b;
        return r;
    endfunction

    function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
        logic signed [31:0] r;
        r = h;
        return r;
    endfunction

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        case (i_memwrite)
            MEMWRITE_SB: begin
                o_be    = 4'b0001 << i_st_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            MEMWRITE_SH: begin
                o_be    = i_st_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            MEMWRITE_SW: begin
                o_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (i_ld_lo)
            2'd0: w_byte = i_rword[7:0];
            2'd1: w_byte = i_rword[15:8];
            2'd2: w_byte = i_rword[23:16];
            2'd3: w_byte = i_rword[31:24];
            default: ;
        endcase
        w_half = i_ld_lo[1] ? i_rword[31:16] : i_rword[15:0];
    end

    always_comb begin
        o_rdata = 32'h0;
        case (i_sizeload)
            SIZELOAD_LB:  o_rdata = $unsigned(sext8(w_byte));
            SIZELOAD_LH:  o_rdata = $unsigned(sext16(w_half));
            SIZELOAD_LW:  o_rdata = i_rword;
            SIZELOAD_LBU: o_rdata = {24'h0, w_byte};
            SIZELOAD_LHU: o_rdata = {16'h0, w_half};
            default:      o_rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// ---------------------------------------------------------------------------
// data_memory_unit
// Responder for the controller's memory commands. Executes byte/half/word
// stores and sign/zero-extending loads against an internal byte-enabled
// word SRAM, and rejects misaligned, out-of-range or conflicting requests.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high; clears the FSM and response, keeps SRAM
//   bus    : data_memory_unit_if.slave (request and response handshakes)
// Timing: store/error response is valid the cycle after accept; a load spends
// one cycle in READ (registered SRAM read) and responds the cycle after.
// req_ready is high only in IDLE, so there is no same-cycle turnaround.
// ---------------------------------------------------------------------------
module data_memory_unit
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
)(
    input  logic             clk,
    input  logic             reset,
    data_memory_unit_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [1:0]       r_state;
    logic [31:0]      r_resp_rdata;
    logic             r_resp_err;
    logic [IDX_W-1:0] r_ld_idx_p0;
    logic [1:0]       r_ld_lo_p0;
    logic [2:0]       r_ld_size_p0;

    logic             w_accept;
    logic             w_is_store;
    logic             w_is_load;
    logic             w_range_err;
    logic             w_err;
    logic             w_store_ok;
    logic             w_load_ok;
    logic [IDX_W-1:0] w_st_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_st_data;
    logic [31:0]      w_rword;
    logic [31:0]      w_ld_data;

    assign w_accept    = bus.req_valid && (r_state == S_IDLE);
    assign w_is_store  = (bus.req_memwrite != MEMWRITE_NONE);
    assign w_is_load   = bus.req_load;
    assign w_range_err = ({1'b0, bus.req_addr} >= ADDR_LIMIT);

    // A request that is neither store nor load never reaches the error path;
    // it is accepted and silently dropped.
    assign w_err = (w_is_store && w_is_load)
                 || ((w_is_store || w_is_load) && w_range_err)
                 || (w_is_store && store_misaligned(bus.req_memwrite, bus.req_addr[1:0]))
                 || (w_is_load  && load_illegal(bus.req_sizeload, bus.req_addr[1:0]));

    assign w_store_ok = w_accept && w_is_store && !w_is_load && !w_err;
    assign w_load_ok  = w_accept && w_is_load && !w_is_store && !w_err;
    assign w_st_idx   = bus.req_addr[IDX_W+1:2];
    assign w_rword    = r_mem[r_ld_idx_p0];

    mem_lane_align u_align (
        .i_memwrite (bus.req_memwrite),
        .i_st_lo    (bus.req_addr[1:0]),
        .i_wdata    (bus.req_wdata),
        .o_be       (w_be),
        .o_wdata    (w_st_data),
        .i_sizeload (r_ld_size_p0),
        .i_ld_lo    (r_ld_lo_p0),
        .i_rword    (w_rword),
        .o_rdata    (w_ld_data)
    );

    // ---- stage p0: accept edge (store write, load address capture) ----
    // Reset suppresses a store accepted on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && w_store_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_st_idx][8*i +: 8] <= w_st_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ld_idx_p0  <= w_st_idx;
            r_ld_lo_p0   <= bus.req_addr[1:0];
            r_ld_size_p0 <= bus.req_sizeload;
        end
    end

    // ---- stage p1: READ registers the extended SRAM word into the response ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (w_is_store || w_is_load)) begin
                        r_resp_rdata <= 32'h0;
                        r_resp_err   <= w_err;
                        r_state      <= w_load_ok ? S_READ : S_RESP;
                    end
                end
                S_READ: begin
                    r_resp_rdata <= w_ld_data;
                    r_resp_err   <= 1'b0;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_rdata <= 32'h0;
                        r_resp_err   <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

endmodule
